// File: rtl/etai_pkg.sv
// Shared widths, FSM state encoding and a small helper for the ETAI32 error monitor.
package etai_pkg;

  localparam int unsigned ETAI_W     = 32;
  localparam int unsigned ETAI_SAE_W = 64;
  localparam int unsigned ETAI_SSE_W = 100;
  localparam int unsigned ETAI_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_REPORT
  } mon_state_e;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/etai_err_diff.sv
// First pipeline stage: signed difference of approximate and accurate sums,
// registered as absolute value plus a nonzero flag with a valid bit.
module etai_err_diff
  import etai_pkg::*;
#(
  parameter int unsigned W = ETAI_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         valid_i,
  input  logic [W-1:0] appx_i,
  input  logic [W-1:0] accr_i,
  output logic         valid_o,
  output logic [W:0]   ad_o,
  output logic         nz_o
);

  logic [W:0] diff;
  logic [W:0] absDiff;
  logic       valid_q;
  logic [W:0] ad_q;
  logic       nz_q;

  // One extra bit keeps the difference exact, so its magnitude never overflows.
  assign diff    = {appx_i[W-1], appx_i} - {accr_i[W-1], accr_i};
  assign absDiff = diff[W] ? (~diff + {{W{1'b0}}, 1'b1}) : diff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ad_q    <= '0;
      nz_q    <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        ad_q <= absDiff;
        nz_q <= |diff;
      end
    end
  end

  assign valid_o = valid_q;
  assign ad_o    = ad_q;
  assign nz_o    = nz_q;

endmodule

// File: rtl/etai_err_monitor.sv
// Running error statistics for the ETAI32 adder against its exact reference,
// with saturating accumulators and a drain/report snapshot handshake.
module etai_err_monitor
  import etai_pkg::*;
#(
  parameter int unsigned W     = ETAI_W,
  parameter int unsigned SAE_W = ETAI_SAE_W,
  parameter int unsigned SSE_W = ETAI_SSE_W,
  parameter int unsigned CNT_W = ETAI_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     appx,
  input  logic [W-1:0]     accr,
  input  logic             clear,
  input  logic             dump_req,
  output logic             stat_valid,
  input  logic             stat_ack,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] err_count,
  output logic [SAE_W-1:0] sae,
  output logic [SSE_W-1:0] sse,
  output logic [W:0]       max_ae,
  output logic             sat
);

  localparam int unsigned SAE_X = maxOf(SAE_W, W + 1) + 1;
  localparam int unsigned SQ_W  = 2 * W + 2;
  localparam int unsigned SSE_X = SSE_W + 1;

  mon_state_e       state_q;
  logic             inReady_q;
  logic             statValid_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;
  logic [SAE_W-1:0] sae_q, sae_d;
  logic [SSE_W-1:0] sse_q, sse_d;
  logic [W:0]       maxAe_q, maxAe_d;
  logic             sat_q;
  logic             satHit;

  logic             xfer;
  logic             v1;
  logic [W:0]       ad;
  logic             nz;

  logic [CNT_W:0]   cntSum;
  logic [CNT_W:0]   errSum;
  logic [SAE_X-1:0] saeSum;
  logic [SQ_W-1:0]  adSq;
  logic [SSE_X-1:0] sseSum;
  logic             saeOvf;

  assign xfer = in_valid && inReady_q;

  etai_err_diff #(.W(W)) u_diff (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .clear_i (clear),
    .valid_i (xfer),
    .appx_i  (appx),
    .accr_i  (accr),
    .valid_o (v1),
    .ad_o    (ad),
    .nz_o    (nz)
  );

  // Every sum carries one guard bit; a set guard bit means clamp to all-ones.
  always_comb begin
    cntSum     = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    errSum     = {1'b0, errCount_q} + {{CNT_W{1'b0}}, nz};
    saeSum     = SAE_X'(sae_q) + SAE_X'(ad);
    adSq       = SQ_W'(ad) * SQ_W'(ad);
    sseSum     = SSE_X'(sse_q) + SSE_X'(adSq);
    saeOvf     = |saeSum[SAE_X-1:SAE_W];
    count_d    = cntSum[CNT_W] ? '1 : cntSum[CNT_W-1:0];
    errCount_d = errSum[CNT_W] ? '1 : errSum[CNT_W-1:0];
    sae_d      = saeOvf ? '1 : saeSum[SAE_W-1:0];
    sse_d      = sseSum[SSE_W] ? '1 : sseSum[SSE_W-1:0];
    maxAe_d    = (ad > maxAe_q) ? ad : maxAe_q;
    satHit     = cntSum[CNT_W] | errSum[CNT_W] | saeOvf | sseSum[SSE_W];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q    <= '0;
      errCount_q <= '0;
      sae_q      <= '0;
      sse_q      <= '0;
      maxAe_q    <= '0;
      sat_q      <= 1'b0;
    end else if (clear) begin
      count_q    <= '0;
      errCount_q <= '0;
      sae_q      <= '0;
      sse_q      <= '0;
      maxAe_q    <= '0;
      sat_q      <= 1'b0;
    end else if (v1) begin
      count_q    <= count_d;
      errCount_q <= errCount_d;
      sae_q      <= sae_d;
      sse_q      <= sse_d;
      maxAe_q    <= maxAe_d;
      sat_q      <= sat_q | satHit;
    end
  end

  // The pipeline is empty once S1 holds no valid pair, since S2 retires in one cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_RUN;
      inReady_q   <= 1'b0;
      statValid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_RUN;
      inReady_q   <= 1'b1;
      statValid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dump_req) begin
            state_q   <= ST_DRAIN;
            inReady_q <= 1'b0;
          end else begin
            inReady_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!v1) begin
            state_q     <= ST_REPORT;
            statValid_q <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (stat_ack) begin
            state_q     <= ST_RUN;
            inReady_q   <= 1'b1;
            statValid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          inReady_q   <= 1'b1;
          statValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = inReady_q;
  assign stat_valid = statValid_q;
  assign count      = count_q;
  assign err_count  = errCount_q;
  assign sae        = sae_q;
  assign sse        = sse_q;
  assign max_ae     = maxAe_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_etai_err_monitor.sv
// Self-checking bench for etai_err_monitor: directed and random pairs checked
// against a running-totals reference model, plus a narrow instance for saturation.
module tb_etai_err_monitor;

  logic         Clk;
  logic         Rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  appx;
  logic [31:0]  accr;
  logic         clear;
  logic         dump_req;
  logic         stat_valid;
  logic         stat_ack;
  logic [31:0]  count;
  logic [31:0]  err_count;
  logic [63:0]  sae;
  logic [99:0]  sse;
  logic [32:0]  max_ae;
  logic         sat;

  logic         sInValid;
  logic         sInReady;
  logic [7:0]   sAppx;
  logic [7:0]   sAccr;
  logic         sClear;
  logic         sDumpReq;
  logic         sStatValid;
  logic         sStatAck;
  logic [7:0]   sCount;
  logic [7:0]   sErrCount;
  logic [7:0]   sSae;
  logic [17:0]  sSse;
  logic [8:0]   sMaxAe;
  logic         sSat;

  int checks   = 0;
  int failures = 0;

  logic [127:0] mCount, mErr, mSae, mSse, mMax;

  etai_err_monitor dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .appx       (appx),
    .accr       (accr),
    .clear      (clear),
    .dump_req   (dump_req),
    .stat_valid (stat_valid),
    .stat_ack   (stat_ack),
    .count      (count),
    .err_count  (err_count),
    .sae        (sae),
    .sse        (sse),
    .max_ae     (max_ae),
    .sat        (sat)
  );

  etai_err_monitor #(.W(8), .SAE_W(8), .SSE_W(18), .CNT_W(8)) dutS (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .in_valid   (sInValid),
    .in_ready   (sInReady),
    .appx       (sAppx),
    .accr       (sAccr),
    .clear      (sClear),
    .dump_req   (sDumpReq),
    .stat_valid (sStatValid),
    .stat_ack   (sStatAck),
    .count      (sCount),
    .err_count  (sErrCount),
    .sae        (sSae),
    .sse        (sSse),
    .max_ae     (sMaxAe),
    .sat        (sSat)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] clampTo(input logic [127:0] v, input int bits);
    logic [127:0] lim;
    lim = (128'd1 << bits) - 128'd1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic modelClear();
    mCount = '0; mErr = '0; mSae = '0; mSse = '0; mMax = '0;
  endtask

  // Reference: every accepted pair folds into saturating running totals.
  task automatic modelAdd(input logic [31:0] a, input logic [31:0] b);
    longint d;
    logic [127:0] ad;
    d  = longint'($signed(a)) - longint'($signed(b));
    ad = (d < 0) ? 128'(-d) : 128'(d);
    mCount = clampTo(mCount + 128'd1, 32);
    if (d != 0) mErr = clampTo(mErr + 128'd1, 32);
    mSae = clampTo(mSae + ad, 64);
    mSse = clampTo(mSse + ad * ad, 100);
    if (ad > mMax) mMax = ad;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] a, input logic [31:0] b,
                               input logic dump);
    logic accepted;
    in_valid = valid;
    appx     = a;
    accr     = b;
    dump_req = dump;
    accepted = valid && in_ready;
    tick();
    in_valid = 1'b0;
    dump_req = 1'b0;
    if (accepted) modelAdd(a, b);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_count"},     128'(count),     mCount);
    check({tag, "_err_count"}, 128'(err_count), mErr);
    check({tag, "_sae"},       128'(sae),       mSae);
    check({tag, "_sse"},       128'(sse),       mSse);
    check({tag, "_max_ae"},    128'(max_ae),    mMax);
    check({tag, "_sat"},       128'(sat),       128'd0);
  endtask

  task automatic waitReport(input string tag);
    int k;
    logic found;
    found = 1'b0;
    for (k = 0; k < 8; k++) begin
      if (stat_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_dump_latency_ok"}, 128'(found && (k <= 3)), 128'd1);
  endtask

  task automatic ackReport(input string tag);
    stat_ack = 1'b1;
    tick();
    stat_ack = 1'b0;
    check({tag, "_ack_stat_valid"}, 128'(stat_valid), 128'd0);
    check({tag, "_ack_in_ready"},   128'(in_ready),   128'd1);
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    modelClear();
  endtask

  initial begin
    in_valid = 0; appx = 0; accr = 0; clear = 0; dump_req = 0; stat_ack = 0;
    sInValid = 0; sAppx = 0; sAccr = 0; sClear = 0; sDumpReq = 0; sStatAck = 0;
    modelClear();
    Rst_n = 1'b0;
    #12;
    check("rst_in_ready",   128'(in_ready),   128'd0);
    check("rst_stat_valid", 128'(stat_valid), 128'd0);
    checkOutput("rst");
    #10 Rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Latency: single pair visible two edges after transfer
    applyStimulus(1'b1, 32'd3, 32'd1, 1'b0);
    tick();
    tick();
    check("lat_count", 128'(count), 128'd1);
    check("lat_sae",   128'(sae),   128'd2);
    doClear();
    check("clr_count", 128'(count), 128'd0);

    // Directed example with dump on the last back-to-back transfer
    applyStimulus(1'b1, 32'd10, 32'd7, 1'b0);
    applyStimulus(1'b1, -32'sd5, -32'sd5, 1'b0);
    applyStimulus(1'b1, 32'd0, 32'd4, 1'b1);
    check("dir_drain_in_ready", 128'(in_ready), 128'd0);
    waitReport("dir");
    check("dir_report_in_ready", 128'(in_ready), 128'd0);
    applyStimulus(1'b1, 32'd1000, 32'd0, 1'b0);
    checkOutput("dir");
    check("dir_const_count", 128'(count),     128'd3);
    check("dir_const_err",   128'(err_count), 128'd2);
    check("dir_const_sae",   128'(sae),       128'd7);
    check("dir_const_sse",   128'(sse),       128'd25);
    check("dir_const_max",   128'(max_ae),    128'd4);
    ackReport("dir");

    // Extreme difference
    doClear();
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    waitReport("ext");
    checkOutput("ext");
    check("ext_const_max", 128'(max_ae), 128'hFFFF_FFFF);
    check("ext_const_sse", 128'(sse),    128'hFFFF_FFFE_0000_0001);
    ackReport("ext");

    // Random rounds, cumulative across dumps
    doClear();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(12, 4);
      for (int i = 0; i < n; i++) begin
        logic [31:0] a, b;
        if (r[0]) begin
          a = $urandom;
          b = $urandom;
        end else begin
          a = 32'($urandom_range(40, 0)) - 32'd20;
          b = 32'($urandom_range(40, 0)) - 32'd20;
        end
        if ($urandom_range(3, 0) == 0) applyStimulus(1'b0, a, b, 1'b0);
        applyStimulus(1'b1, a, b, (i == n - 1));
      end
      waitReport($sformatf("rnd%0d", r));
      checkOutput($sformatf("rnd%0d", r));
      ackReport($sformatf("rnd%0d", r));
    end

    // Clear together with ack in REPORT
    applyStimulus(1'b1, 32'd9, 32'd2, 1'b1);
    waitReport("clrack");
    clear    = 1'b1;
    stat_ack = 1'b1;
    tick();
    clear    = 1'b0;
    stat_ack = 1'b0;
    modelClear();
    check("clrack_stat_valid", 128'(stat_valid), 128'd0);
    check("clrack_in_ready",   128'(in_ready),   128'd1);
    checkOutput("clrack");

    // Asynchronous reset while draining
    applyStimulus(1'b1, 32'd50, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd60, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd70, 32'd0, 1'b1);
    check("rstdrain_in_ready_pre", 128'(in_ready), 128'd0);
    #2 Rst_n = 1'b0;
    #1;
    modelClear();
    check("rstdrain_in_ready",   128'(in_ready),   128'd0);
    check("rstdrain_stat_valid", 128'(stat_valid), 128'd0);
    checkOutput("rstdrain");
    #3 Rst_n = 1'b1;
    tick();
    check("rstdrain_post_in_ready", 128'(in_ready), 128'd1);
    applyStimulus(1'b1, 32'd5, 32'd8, 1'b0);
    applyStimulus(1'b1, 32'd6, 32'd6, 1'b1);
    waitReport("postrst");
    checkOutput("postrst");
    ackReport("postrst");

    // Saturation on the narrow instance (8-bit SAE clamps at 0xFF)
    check("sat_in_ready", 128'(sInReady), 128'd1);
    sInValid = 1'b1; sAppx = 8'h7F; sAccr = 8'h80;
    tick();
    sInValid = 1'b0;
    tick();
    tick();
    check("sat1_sae", 128'(sSae), 128'd255);
    check("sat1_sat", 128'(sSat), 128'd0);
    sInValid = 1'b1;
    tick();
    sInValid = 1'b0;
    tick();
    tick();
    check("sat2_sae",   128'(sSae),   128'd255);
    check("sat2_sat",   128'(sSat),   128'd1);
    check("sat2_count", 128'(sCount), 128'd2);
    check("sat2_sse",   128'(sSse),   128'd130050);
    check("sat2_max",   128'(sMaxAe), 128'd255);
    sInValid = 1'b1; sAppx = 8'd5; sAccr = 8'd5;
    tick();
    sInValid = 1'b0;
    tick();
    tick();
    check("sat3_sticky", 128'(sSat),   128'd1);
    check("sat3_count",  128'(sCount), 128'd3);
    sClear = 1'b1;
    tick();
    sClear = 1'b0;
    check("satclr_sat", 128'(sSat), 128'd0);
    check("satclr_sae", 128'(sSae), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
